// File: rtl/router_pkg.sv
// Shared types and constants for the router packet controller and its soft-reset timers.
// Pure declarations; no logic, no latency, no flow control.
package router_pkg;

    localparam int NUM_PORTS          = 3;
    localparam int ADDR_W             = 2;
    localparam int SOFT_RESET_TIMEOUT = 30;
    localparam int TMR_W              = $clog2(SOFT_RESET_TIMEOUT);

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_PARITY,
        CHECK_PARITY_ERROR
    } state_t;

endpackage

// File: rtl/router_softreset_timer.sv
// Per-port idle-reader watchdog: pulses soft_reset when data sits unread for SOFT_RESET_TIMEOUT cycles.
// Latency: pulse is registered, one cycle after the timeout-th stalled cycle.
// Backpressure: none; any read or empty port clears the count.
module router_softreset_timer
    import router_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (!vld || rd) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (cnt == TMR_W'(SOFT_RESET_TIMEOUT - 1)) begin
            cnt        <= '0;
            soft_reset <= 1'b1;
        end else begin
            cnt        <= cnt + 1'b1;
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_pkt_ctrl.sv
// Router packet controller: steers header/payload/parity bytes into one of three output FIFOs.
// Latency: header written 2 cycles after acceptance (3+ if the FIFO must drain), payload 1 byte/cycle.
// Backpressure: busy holds the source while waiting for an empty/non-full FIFO; ROUTER_SOFT_RESET_EN adds read timers.
module router_pkt_ctrl
    import router_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [7:0]           data_in,
    input  logic [NUM_PORTS-1:0] full,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic [7:0]           dout,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 lfd_state,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic                 parity_error
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] hdr_addr;
    logic [7:0]        parity;
    logic              abort;

    assign hdr_addr = data_in[ADDR_W-1:0];
    assign vld_out  = ~empty;
    // A soft reset of the destination FIFO drops the packet in flight.
    assign abort    = (state != DECODE_ADDRESS) && soft_reset[dest];

    always_ff @(posedge clock) begin
        if (reset) state <= DECODE_ADDRESS;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DECODE_ADDRESS:
                if (pkt_valid && hdr_addr != INVALID_ADDR)
                    state_nxt = empty[hdr_addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            WAIT_TILL_EMPTY:    if (empty[dest]) state_nxt = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:    state_nxt = LOAD_DATA;
            LOAD_DATA:
                if (full[dest])      state_nxt = FIFO_FULL_STATE;
                else if (!pkt_valid) state_nxt = LOAD_PARITY;
            FIFO_FULL_STATE:    if (!full[dest]) state_nxt = LOAD_DATA;
            LOAD_PARITY:        if (!full[dest]) state_nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_nxt = DECODE_ADDRESS;
            default:            state_nxt = DECODE_ADDRESS;
        endcase
        if (abort) state_nxt = DECODE_ADDRESS;
    end

    always_comb begin
        busy      = 1'b1;
        lfd_state = 1'b0;
        write_enb = '0;
        case (state)
            DECODE_ADDRESS:  busy = 1'b0;
            LOAD_FIRST_DATA: lfd_state = 1'b1;
            LOAD_DATA:
                if (!full[dest]) begin
                    busy            = 1'b0;
                    write_enb[dest] = !abort;
                end
            LOAD_PARITY:     if (!full[dest]) write_enb[dest] = !abort;
            default:         ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dout         <= '0;
            dest         <= '0;
            parity       <= '0;
            parity_error <= 1'b0;
        end else begin
            if (!busy) dout <= data_in;
            if (state == DECODE_ADDRESS) begin
                parity <= '0;
                if (state_nxt != DECODE_ADDRESS) dest <= hdr_addr;
            end
            // Header and payload only; the parity byte goes out from LOAD_PARITY.
            if (state == LOAD_DATA && |write_enb) parity <= parity ^ dout;
            // dout still holds the received parity byte while busy is high.
            if (state == CHECK_PARITY_ERROR) parity_error <= (parity != dout);
        end
    end

`ifdef ROUTER_SOFT_RESET_EN
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_tmr
        router_softreset_timer u_tmr (
            .clock      (clock),
            .reset      (reset),
            .vld        (vld_out[g]),
            .rd         (read_enb[g]),
            .soft_reset (soft_reset[g])
        );
    end
`else
    logic unused_read_enb;
    assign unused_read_enb = ^read_enb;
    assign soft_reset      = '0;
`endif

endmodule
